// File: rtl/data_memory_responder.sv
// Byte-addressed big-endian data memory serving MEM-stage loads/stores as multi-cycle
// transactions. Define DATA_MEM_ALIGN_CHECK_EN to reject misaligned accesses via err.
module data_memory_responder #(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        R,
    input  logic        DataMem_enable,
    input  logic        Read_Write,
    input  logic [1:0]  size_dm,
    input  logic        SE_dm,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            rw_q;
    logic [1:0]      size_q;
    logic            se_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     data_q;

    logic [7:0]      mem [DEPTH];

    logic            idle;
    logic            accept;
    logic            access;
    logic            wr_en;
    logic            misaligned;
    logic            acc_rw;
    logic [1:0]      acc_size;
    logic            acc_se;
    logic [AW-1:0]   acc_addr;
    logic [31:0]     acc_data;
    logic [AW-1:0]   acc_a0;
    logic [AW-1:0]   acc_a1;
    logic [AW-1:0]   acc_a2;
    logic [AW-1:0]   acc_a3;
    logic [7:0]      b0;
    logic [7:0]      b1;
    logic [7:0]      b2;
    logic [7:0]      b3;
    logic [31:0]     load_value;

    logic            unused_addr;
    assign unused_addr = ^Address[31:AW];

    // With zero wait states the access happens on the acceptance edge, so the live
    // request fields are used in IDLE and the latched copy everywhere else.
    always_comb begin
        idle   = (state_q == StIdle);
        accept = idle && DataMem_enable;
        if (idle) begin
            acc_rw   = Read_Write;
            acc_size = size_dm;
            acc_se   = SE_dm;
            acc_addr = Address[AW-1:0];
            acc_data = DataIn;
        end else begin
            acc_rw   = rw_q;
            acc_size = size_q;
            acc_se   = se_q;
            acc_addr = addr_q;
            acc_data = data_q;
        end
        access = (accept && (WAIT_CYCLES == 0)) || ((state_q == StWait) && (cnt_q == 4'd0));
    end

    assign acc_a0 = acc_addr;
    assign acc_a1 = acc_addr + AW'(1);
    assign acc_a2 = acc_addr + AW'(2);
    assign acc_a3 = acc_addr + AW'(3);

    assign b0 = mem[acc_a0];
    assign b1 = mem[acc_a1];
    assign b2 = mem[acc_a2];
    assign b3 = mem[acc_a3];

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign misaligned = ((acc_size == 2'b01) && acc_addr[0]) ||
                        (acc_size[1] && (acc_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        load_value = {b0, b1, b2, b3};
        case (acc_size)
            2'b00:   load_value = {{24{acc_se & b0[7]}}, b0};
            2'b01:   load_value = {{16{acc_se & b0[7]}}, b0, b1};
            default: load_value = {b0, b1, b2, b3};
        endcase
    end

    assign stall = accept || (state_q == StWait);

    // Reset is checked at the edge too, so a store caught by reset never lands.
    assign wr_en = access && acc_rw && !misaligned && !R;

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            case (acc_size)
                2'b00: begin
                    mem[acc_a0] <= acc_data[7:0];
                end
                2'b01: begin
                    mem[acc_a0] <= acc_data[15:8];
                    mem[acc_a1] <= acc_data[7:0];
                end
                default: begin
                    mem[acc_a0] <= acc_data[31:24];
                    mem[acc_a1] <= acc_data[23:16];
                    mem[acc_a2] <= acc_data[15:8];
                    mem[acc_a3] <= acc_data[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            se_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            DataOut <= 32'd0;
            done    <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (DataMem_enable) begin
                        rw_q    <= Read_Write;
                        size_q  <= size_dm;
                        se_q    <= SE_dm;
                        addr_q  <= Address[AW-1:0];
                        data_q  <= DataIn;
                        cnt_q   <= WaitLoad;
                        state_q <= (WAIT_CYCLES == 0) ? StDone : StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            done <= access && !misaligned;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            err  <= access && misaligned;
`endif
            if (access && !misaligned && !acc_rw) begin
                DataOut <= load_value;
            end
        end
    end

`ifndef DATA_MEM_ALIGN_CHECK_EN
    assign err = 1'b0;
`endif

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

- Byte-addressed, big-endian data memory that serves load/store requests issued by the MEM stage.
- It consumes the memory control bundle produced by decode: enable, read/write, size, sign-extend.
- Each accepted request runs as a multi-cycle transaction:
  - it holds the pipeline with `stall` while in progress;
  - it signals completion with a one-cycle `done` pulse and registered load data.

## Interface

Parameters:
- `DEPTH`, 512: memory size in bytes; must be a power of two.
- `WAIT_CYCLES`, 1: wait states between acceptance and completion (0–15).

Ports:
- `Clk` in 1: rising-edge clock.
- `R` in 1: reset, asynchronous, active-high.
- `DataMem_enable` in 1: request present.
- `Read_Write` in 1: 0 = load, 1 = store.
- `size_dm` in 2: 00 byte, 01 halfword, 10 word, 11 treated as word.
- `SE_dm` in 1: sign-extend byte/halfword loads.
- `Address` in 32: byte address; only low log2(DEPTH) bits are used.
- `DataIn` in 32: store data, right-justified.
- `DataOut` out 32: load result, registered.
- `stall` out 1: hold upstream pipeline registers.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle misalignment pulse; only exists under `ALIGN_CHECK_EN`, otherwise tied 0.

## Operation

- States:
  - IDLE: no transaction.
  - WAIT: counting wait states.
  - DONE: completion cycle.
- IDLE:
  - With `DataMem_enable`=1, latch `Read_Write`, `size_dm`, `SE_dm`, masked address and `DataIn` at the edge.
  - Then go to WAIT, or to DONE if `WAIT_CYCLES`=0.
- WAIT:
  - The counter loads `WAIT_CYCLES`-1 on acceptance and decrements each cycle.
  - At 0, go to DONE.
  - Request inputs are ignored (latched copy used).
- Memory access happens on the edge entering DONE.
- Store (big-endian, on that edge):
  - byte writes `DataIn[7:0]` to A;
  - halfword writes `[15:8]` to A and `[7:0]` to A+1;
  - word writes `[31:24]` to A through `[7:0]` to A+3.
- Load: `DataOut` is updated on that edge.
  - Byte: {24 × (SE ? bit7 : 0), M[A]}.
  - Halfword: {16 × (SE ? bit15 : 0), M[A], M[A+1]}.
  - Word: M[A]..M[A+3].
- Byte indices wrap modulo `DEPTH` (A+k masked).
- Stores leave `DataOut` unchanged.
- DONE:
  - `done`=1 for exactly one cycle; always returns to IDLE.
  - `DataMem_enable` seen in DONE is the same instruction and is not re-accepted.
- `stall` is combinational: (IDLE && `DataMem_enable`) || WAIT. It is 0 in DONE so the pipeline advances at the end of DONE.
- Back-to-back requests: a new request is accepted in the IDLE cycle following DONE.
- The memory array is not cleared by reset; testbenches preload it hierarchically.

## Timing

- Reset values: state IDLE, `DataOut`=0, `done`=0, `err`=0, counter 0. `stall` follows its combinational equation (0 when enable is low).
- Reset asserted mid-transaction:
  - return immediately to IDLE;
  - the pending store is discarded and no byte is modified;
  - no `done` pulse.
- Latency: `done` rises `WAIT_CYCLES`+1 cycles after the acceptance edge.
  - The stall window is `WAIT_CYCLES`+1 cycles (acceptance cycle plus WAIT cycles).
  - Throughput is one transaction per `WAIT_CYCLES`+2 cycles.
- `DataOut` holds its value until the next load completes.

## Configuration

- `DATA_MEM_ALIGN_CHECK_EN` defined:
  - Misalignment is a halfword with A[0]=1, or a word with A[1:0]≠0.
  - A misaligned request still goes through the full FSM.
  - In DONE it pulses `err` instead of `done`.
  - The memory is unmodified and `DataOut` is unchanged.
- Undefined: `err` is tied 0 and unaligned accesses proceed byte-wise per the rules above.

## Test plan

- Reset, then preload M[0..3]=DE AD BE EF; word load A=0 → `stall` high for 2 cycles, `done` pulses on cycle 2, `DataOut`=DEADBEEF.
- Byte load A=1 (0xAD) with `SE_dm`=1 → `DataOut`=FFFFFFAD. With `SE_dm`=0 → `DataOut`=000000AD. Halfword load A=2 with SE=1 → FFFFBEEF.
- Word store A=8, `DataIn`=12345678, then byte store A=9 data 0xAA, then word load A=8 → `DataOut`=12AA5678. Back-to-back acceptance occurs on the IDLE cycle after each DONE.
- Word load at A=`DEPTH`-2 with M[510..511]=01 02, M[0..1]=03 04 → `DataOut`=01020304 (wrap); run with ALIGN_CHECK off.
- Start a store to A=16, assert `R` during WAIT → FSM in IDLE, no `done`, M[16..19] unchanged, `DataOut`=0.
- With `DATA_MEM_ALIGN_CHECK_EN`: word store A=6 → `err` pulses once, `done` stays 0, M[6..9] unchanged.
